// File: rtl/p2s_s2p_param_if.sv
// p2s_s2p_param_if
// Handshake and data bundle of the loopback serializer/deserializer.
// The clock and reset stay plain ports on the block itself.
//   IN_ENB        global enable, low stalls TX and RX
//   IN_VALID      parallel word offered
//   OUT_READY     block accepts the offered word this cycle
//   IN_DIR        1 = MSB chunk first, 0 = LSB chunk first (sampled at capture)
//   IN_LANES      LANES x WIDTH parallel word, lane k at [WIDTH*k +: WIDTH]
//   OUT_SER       serial chunk currently on the internal bus (probe)
//   OUT_SER_VALID strobe on the last cycle of each beat
//   OUT_LANES     reassembled word
//   OUT_VALID     one-cycle pulse when OUT_LANES is updated
//   OUT_BUSY      TX is shifting a frame
interface p2s_s2p_param_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int SER_W = 4
);
   logic                     IN_ENB;
   logic                     IN_VALID;
   logic                     OUT_READY;
   logic                     IN_DIR;
   logic [WIDTH*LANES-1:0]   IN_LANES;
   logic [SER_W-1:0]         OUT_SER;
   logic                     OUT_SER_VALID;
   logic [WIDTH*LANES-1:0]   OUT_LANES;
   logic                     OUT_VALID;
   logic                     OUT_BUSY;

   // word source side
   modport master (
      output IN_ENB, IN_VALID, IN_DIR, IN_LANES,
      input  OUT_READY, OUT_SER, OUT_SER_VALID, OUT_LANES, OUT_VALID, OUT_BUSY
   );

   // serializer/deserializer side
   modport slave (
      input  IN_ENB, IN_VALID, IN_DIR, IN_LANES,
      output OUT_READY, OUT_SER, OUT_SER_VALID, OUT_LANES, OUT_VALID, OUT_BUSY
   );
endinterface

// File: rtl/p2s_s2p_param.sv
// p2s_s2p_param
// Single-clock loopback serializer/deserializer. A captured LANES x WIDTH
// word is sent SER_W bits per beat over an internal bus, one beat every DIV
// enabled cycles, and reassembled on the receive side. Back-to-back frames
// are gapless: a new word can be captured on the final strobe of the
// current one.
// Ports:
//   IN_CLK    clock, rising edge
//   IN_RESET  asynchronous reset, active low
//   bus       p2s_s2p_param_if slave modport (handshake, data, status)
module p2s_s2p_param #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int SER_W = 4,
   parameter int DIV   = 1
) (
   input logic               IN_CLK,
   input logic               IN_RESET,
   p2s_s2p_param_if.slave    bus
);
   localparam int N     = WIDTH * LANES;
   localparam int BEATS = N / SER_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

   if ((N % SER_W) != 0) begin : g_bad_ser_w
      $error("p2s_s2p_param: WIDTH*LANES must be a multiple of SER_W");
   end
   if (DIV < 1) begin : g_bad_div
      $error("p2s_s2p_param: DIV must be >= 1");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    div_cnt;
   logic [BW-1:0]    beat_cnt;
   logic [N-1:0]     sh;          // TX shift register
   logic [N-1:0]     acc;         // RX accumulator
   logic [N-1:0]     out_lanes;
   logic             dir_q;
   logic             pend;        // completed frame waiting for an enabled cycle

   logic             en, strobe, last_beat, fin, ready, cap;
   logic [SER_W-1:0] chunk;
   logic [N-1:0]     sh_nxt, acc_nxt;
   logic [N+SER_W-1:0] sh_ext, acc_ext;

   assign en        = bus.IN_ENB;
   assign strobe    = en && (state == SHIFT) && (div_cnt == DW'(DIV - 1));
   assign last_beat = (beat_cnt == BW'(BEATS - 1));
   assign fin       = strobe && last_beat;
   // reset term keeps OUT_READY low while the block is held in reset
   assign ready     = IN_RESET && en && ((state == IDLE) || fin);
   assign cap       = bus.IN_VALID && ready;

   assign chunk = dir_q ? sh[N-1 -: SER_W] : sh[SER_W-1:0];

   // Shifts done through an extended vector so BEATS == 1 needs no special case.
   // MSB-first: drop top chunk, refill at the bottom; LSB-first: the reverse.
   always_comb begin
      sh_ext  = '0;
      acc_ext = '0;
      if (dir_q) begin
         sh_ext  = {sh, {SER_W{1'b0}}};
         sh_nxt  = sh_ext[N-1:0];
         acc_ext = {acc, chunk};
         acc_nxt = acc_ext[N-1:0];
      end else begin
         sh_ext  = {{SER_W{1'b0}}, sh};
         sh_nxt  = sh_ext[N+SER_W-1:SER_W];
         acc_ext = {chunk, acc};
         acc_nxt = acc_ext[N+SER_W-1:SER_W];
      end
   end

   // TX FSM
   always_ff @(posedge IN_CLK or negedge IN_RESET) begin
      if (!IN_RESET) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cap) state_nxt = SHIFT;
         SHIFT:   if (fin && !cap) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // TX datapath: capture, DIV pacing, beat counting
   always_ff @(posedge IN_CLK or negedge IN_RESET) begin
      if (!IN_RESET) begin
         div_cnt  <= '0;
         beat_cnt <= '0;
         sh       <= '0;
         dir_q    <= 1'b0;
      end else if (cap) begin
         div_cnt  <= '0;
         beat_cnt <= '0;
         sh       <= bus.IN_LANES;
         dir_q    <= bus.IN_DIR;
      end else if (en && (state == SHIFT)) begin
         if (strobe) begin
            div_cnt  <= '0;
            beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            sh       <= sh_nxt;
         end else begin
            div_cnt  <= div_cnt + DW'(1);
         end
      end
   end

   // RX: accumulate on every strobe; the final strobe publishes the word.
   // acc_nxt uses the frame's own direction even when a new word is
   // captured on that same edge.
   always_ff @(posedge IN_CLK or negedge IN_RESET) begin
      if (!IN_RESET) begin
         acc       <= '0;
         out_lanes <= '0;
         pend      <= 1'b0;
      end else begin
         if (strobe) acc <= acc_nxt;
         if (fin)    out_lanes <= acc_nxt;
         // pulse is deferred past stalled cycles rather than dropped
         if (en)     pend <= fin;
      end
   end

   assign bus.OUT_READY     = ready;
   assign bus.OUT_SER       = chunk;
   assign bus.OUT_SER_VALID = strobe;
   assign bus.OUT_LANES     = out_lanes;
   assign bus.OUT_VALID     = pend && en;
   assign bus.OUT_BUSY      = (state == SHIFT);
endmodule

// File: tb/tb_p2s_s2p_param.sv
module tb_p2s_s2p_param;
   localparam int BEATS = 8;
   localparam int DIVS [2] = '{1, 8};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // per-DUT stimulus (index 0: DIV=1, index 1: DIV=8)
   logic        en  [2];
   logic        vin [2];
   logic        dir [2];
   logic [31:0] lin [2];
   // per-DUT observed outputs
   logic        rdy [2];
   logic        sv  [2];
   logic        ov  [2];
   logic        bsy [2];
   logic [3:0]  ser [2];
   logic [31:0] olv [2];

   p2s_s2p_param_if #(.WIDTH(8), .LANES(4), .SER_W(4)) if1 ();
   p2s_s2p_param_if #(.WIDTH(8), .LANES(4), .SER_W(4)) if8 ();

   p2s_s2p_param #(.WIDTH(8), .LANES(4), .SER_W(4), .DIV(1)) u_div1 (
      .IN_CLK(clk), .IN_RESET(rst_n), .bus(if1));
   p2s_s2p_param #(.WIDTH(8), .LANES(4), .SER_W(4), .DIV(8)) u_div8 (
      .IN_CLK(clk), .IN_RESET(rst_n), .bus(if8));

   assign if1.IN_ENB = en[0];  assign if1.IN_VALID = vin[0];
   assign if1.IN_DIR = dir[0]; assign if1.IN_LANES = lin[0];
   assign if8.IN_ENB = en[1];  assign if8.IN_VALID = vin[1];
   assign if8.IN_DIR = dir[1]; assign if8.IN_LANES = lin[1];
   assign rdy[0] = if1.OUT_READY; assign rdy[1] = if8.OUT_READY;
   assign sv[0]  = if1.OUT_SER_VALID; assign sv[1] = if8.OUT_SER_VALID;
   assign ov[0]  = if1.OUT_VALID; assign ov[1] = if8.OUT_VALID;
   assign bsy[0] = if1.OUT_BUSY;  assign bsy[1] = if8.OUT_BUSY;
   assign ser[0] = if1.OUT_SER;   assign ser[1] = if8.OUT_SER;
   assign olv[0] = if1.OUT_LANES; assign olv[1] = if8.OUT_LANES;

   int total = 0;
   int bad   = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a frame is BEATS*DIV enabled cycles long; chunk b is
   // cut arithmetically from the captured word; the word is delivered on
   // the first enabled cycle after the frame's last cycle.
   bit          act [2];
   int          el  [2];      // enabled cycles elapsed in current frame
   logic [31:0] cw  [2];
   bit          cd  [2];
   bit          pend[2];
   logic [31:0] ol  [2];
   bit          captured [2];
   int          ncyc = 0;
   int          cap_at [2];
   int          vld_at [2];
   logic [31:0] vld_data [2];

   function automatic logic [3:0] chunk_of(logic [31:0] w, bit dr, int b);
      logic [31:0] s;
      s = dr ? (w >> (32 - 4 * (b + 1))) : (w >> (4 * b));
      return s[3:0];
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         act[d] = 0; el[d] = 0; pend[d] = 0; ol[d] = '0; captured[d] = 0;
      end
   endtask

   // one clock cycle: entered at posedge+1 with inputs already driven
   task automatic cyc();
      bit e_rdy [2];
      bit e_stb [2];
      int t;
      for (int d = 0; d < 2; d++) begin
         t = BEATS * DIVS[d];
         e_rdy[d] = en[d] && (!act[d] || el[d] == t - 1);
         e_stb[d] = en[d] && act[d] && (el[d] % DIVS[d] == DIVS[d] - 1);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ready_d%0d", DIVS[d]), rdy[d], e_rdy[d]);
         chk($sformatf("strobe_d%0d", DIVS[d]), sv[d], e_stb[d]);
         chk($sformatf("busy_d%0d", DIVS[d]), bsy[d], act[d]);
         chk($sformatf("ovalid_d%0d", DIVS[d]), ov[d], en[d] && pend[d]);
         chk($sformatf("olanes_d%0d", DIVS[d]), olv[d], ol[d]);
         if (act[d])
            chk($sformatf("ser_d%0d", DIVS[d]), ser[d], chunk_of(cw[d], cd[d], el[d] / DIVS[d]));
         if (ov[d]) begin
            vld_at[d] = ncyc;
            vld_data[d] = olv[d];
         end
      end
      for (int d = 0; d < 2; d++) begin
         t = BEATS * DIVS[d];
         captured[d] = 0;
         if (en[d]) begin
            pend[d] = 0;
            if (act[d]) begin
               el[d]++;
               if (el[d] == t) begin
                  act[d] = 0; pend[d] = 1; ol[d] = cw[d];
               end
            end
            if (e_rdy[d] && vin[d]) begin
               act[d] = 1; el[d] = 0; cw[d] = lin[d]; cd[d] = dir[d];
               cap_at[d] = ncyc; captured[d] = 1;
            end
         end
      end
      ncyc++;
      @(posedge clk); #1;
   endtask

   task automatic run(int n);
      repeat (n) cyc();
   endtask

   // offer a word and hold it until accepted; leaves IN_VALID high
   task automatic send(int d, logic [31:0] w, logic dr);
      bit got;
      got = 0;
      vin[d] = 1; lin[d] = w; dir[d] = dr;
      for (int i = 0; i < 200 && !got; i++) begin
         cyc();
         got = captured[d];
      end
      chk($sformatf("send_d%0d", DIVS[d]), got, 1);
   endtask

   // asynchronous reset asserted mid-cycle
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ready_d%0d", DIVS[d]), rdy[d], 0);
         chk($sformatf("rst_strobe_d%0d", DIVS[d]), sv[d], 0);
         chk($sformatf("rst_ovalid_d%0d", DIVS[d]), ov[d], 0);
         chk($sformatf("rst_busy_d%0d", DIVS[d]), bsy[d], 0);
         chk($sformatf("rst_ser_d%0d", DIVS[d]), ser[d], 0);
         chk($sformatf("rst_lanes_d%0d", DIVS[d]), olv[d], 0);
      end
      model_clear();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         en[d] = 0; vin[d] = 0; dir[d] = 0; lin[d] = '0;
         cap_at[d] = 0; vld_at[d] = 0; vld_data[d] = '0; cw[d] = '0; cd[d] = 0;
      end
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      en[0] = 1; en[1] = 1;
      run(3);

      // reset mid-cycle, then ready right after release
      do_reset();
      run(1);

      // single word MSB first, then LSB first
      send(0, 32'hA5C31E7F, 1'b1); vin[0] = 0;
      run(12);
      chk("t2_latency", vld_at[0] - cap_at[0], 9);
      chk("t2_data", vld_data[0], 32'hA5C31E7F);
      send(0, 32'hA5C31E7F, 1'b0); vin[0] = 0;
      run(12);
      chk("t3_latency", vld_at[0] - cap_at[0], 9);
      chk("t3_data", vld_data[0], 32'hA5C31E7F);

      // back-to-back with IN_VALID held
      begin
         int c1, v1;
         logic [31:0] d1;
         send(0, 32'h11223344, 1'b1);
         c1 = cap_at[0];
         send(0, 32'hDEADBEEF, 1'b0);
         chk("t4_gap", cap_at[0] - c1, 8);
         vin[0] = 0;
         run(1);
         v1 = vld_at[0]; d1 = vld_data[0];
         chk("t4_first_at", v1 - c1, 9);
         chk("t4_first_data", d1, 32'h11223344);
         run(12);
         chk("t4_second_at", vld_at[0] - c1, 17);
         chk("t4_second_data", vld_data[0], 32'hDEADBEEF);
      end

      // DIV=8, then DIV=8 with a 5-cycle stall inside beat 3
      send(1, 32'h0F0F0F0F, 1'b1); vin[1] = 0;
      run(70);
      chk("t5_latency", vld_at[1] - cap_at[1], 65);
      chk("t5_data", vld_data[1], 32'h0F0F0F0F);
      send(1, 32'h0F0F0F0F, 1'b0); vin[1] = 0;
      run(3 * 8 + 2);
      en[1] = 0;
      run(5);
      en[1] = 1;
      run(50);
      chk("t5_stall_latency", vld_at[1] - cap_at[1], 70);
      chk("t5_stall_data", vld_data[1], 32'h0F0F0F0F);

      // reset during beat 4, then a clean frame
      send(0, 32'hCAFEF00D, 1'b1); vin[0] = 0;
      run(4);
      do_reset();
      chk("t6_lanes_cleared", olv[0], 0);
      run(12);
      send(0, 32'h12345678, 1'b1); vin[0] = 0;
      run(12);
      chk("t6_latency", vld_at[0] - cap_at[0], 9);
      chk("t6_data", vld_data[0], 32'h12345678);

      // randomized traffic, stalls and direction changes on both instances
      for (int i = 0; i < 3000; i++) begin
         for (int d = 0; d < 2; d++) begin
            en[d]  = ($urandom_range(0, 9) != 0);
            vin[d] = $urandom_range(0, 1);
            dir[d] = $urandom_range(0, 1);
            lin[d] = $urandom;
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
